decode_stage_0_q: RTL and testbench

Parametrised, registered successor to the stage-0 instruction length decoder. Each cycle it computes the length and field layout of the instruction at the head of the fetch window. On acceptance it writes a decoded record into an OUT_DEPTH-entry output queue, so `f_ready` never depends combinationally on `s0_ready`. It also tracks HLT, holding the front end stalled until an interrupt or flush. It sits between fetch and decode stage 1.

---
 rtl/decode_stage_0_q.sv | 264 ++++++++++++++++++++++++++
 tb/tb_decode_stage_0_q.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_0_q.sv
// decode_stage_0_q
//   Stage-0 instruction length decoder with a registered output queue.
//   Measures the instruction at the head of the fetch window and splits it
//   into prefix, opcode, ModRM/SIB, displacement and immediate fields. An
//   accepted instruction is written into an OUT_DEPTH-entry queue, so
//   f_ready never depends on s0_ready. An HLT instruction stalls the front
//   end until an interrupt or a flush.
// Ports
//   clk, reset (async, active-low), flush, handle_int, halt
//   f_*  : fetch window in (f_valid, f_valid_bytes, f_instruction, f_pc,
//          f_branch_taken), acceptance out (f_ready, f_bytes_read)
//   s0_* : decoded record out with s0_valid / s0_ready handshake
module decode_stage_0_q #(
  parameter int IADDRW       = 32,
  parameter int WINDOW_BYTES = 16,
  parameter int CNTW         = 6,
  parameter int OUT_DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      handle_int,
  output logic                      halt,
  input  logic                      f_valid,
  output logic                      f_ready,
  output logic [CNTW-1:0]           f_bytes_read,
  input  logic [CNTW-1:0]           f_valid_bytes,
  input  logic [8*WINDOW_BYTES-1:0] f_instruction,
  input  logic [IADDRW-1:0]         f_pc,
  input  logic                      f_branch_taken,
  output logic                      s0_valid,
  input  logic                      s0_ready,
  output logic [23:0]               s0_prefix,
  output logic [1:0]                s0_prefix_bytes,
  output logic [15:0]               s0_opcode,
  output logic [1:0]                s0_opcode_bytes,
  output logic [15:0]               s0_addressing,
  output logic [1:0]                s0_addressing_bytes,
  output logic [3:0]                s0_displacement_bytes,
  output logic [3:0]                s0_immediete_bytes,
  output logic [63:0]               s0_displace_n_imm,
  output logic [4:0]                s0_length,
  output logic [IADDRW-1:0]         s0_pc,
  output logic                      s0_branch_taken,
  output logic                      s0_size_override
);
  localparam int WINW = 8 * WINDOW_BYTES;
  localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW   = $clog2(OUT_DEPTH + 1);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic [23:0]       prefix;
    logic [1:0]        prefix_n;
    logic [15:0]       opcode;
    logic [1:0]        opcode_n;
    logic [15:0]       addressing;
    logic [1:0]        addressing_n;
    logic [3:0]        disp_n;
    logic [3:0]        imm_n;
    logic [63:0]       dni;
    logic [4:0]        length;
    logic [IADDRW-1:0] pc;
    logic              branch_taken;
    logic              size_ovr;
  } rec_t;

  function automatic logic [7:0] byte_at(input logic [WINW-1:0] w, input logic [3:0] idx);
    logic [WINW-1:0] s;
    s = w >> {idx, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
      8'h26, 8'h64, 8'h65, 8'h66, 8'h67: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  rec_t             mem_q [OUT_DEPTH];
  rec_t             rec_d, rec_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic             halt_q;

  logic [7:0]       b0, b1, b2, op0, op1, modrm, sib;
  logic [1:0]       pfx_n, op_n, addr_n;
  logic [3:0]       disp_n, imm_n, immz, start, dni_n;
  logic             size_ovr, addr_ovr, has_modrm;
  logic [WINW-1:0]  dni_sh;
  logic [63:0]      dni;
  logic [4:0]       len;
  logic             fire, pop;

  // Length decode on the head of the fetch window
  always_comb begin
    b0 = byte_at(f_instruction, 4'd0);
    b1 = byte_at(f_instruction, 4'd1);
    b2 = byte_at(f_instruction, 4'd2);
    pfx_n = 2'd0;
    if (is_prefix(b0)) begin
      pfx_n = 2'd1;
      if (is_prefix(b1)) begin
        pfx_n = 2'd2;
        if (is_prefix(b2)) pfx_n = 2'd3;
      end
    end
    size_ovr = (pfx_n >= 2'd1 && b0 == 8'h66) || (pfx_n >= 2'd2 && b1 == 8'h66) ||
               (pfx_n == 2'd3 && b2 == 8'h66);
    addr_ovr = (pfx_n >= 2'd1 && b0 == 8'h67) || (pfx_n >= 2'd2 && b1 == 8'h67) ||
               (pfx_n == 2'd3 && b2 == 8'h67);
    op0   = byte_at(f_instruction, {2'b00, pfx_n});
    op1   = byte_at(f_instruction, {2'b00, pfx_n} + 4'd1);
    op_n  = (op0 == 8'h0F) ? 2'd2 : 2'd1;
    modrm = byte_at(f_instruction, {2'b00, pfx_n} + {2'b00, op_n});
    sib   = byte_at(f_instruction, {2'b00, pfx_n} + {2'b00, op_n} + 4'd1);
    // imm16/32 forms shrink to 16 bits under the operand-size prefix
    immz      = size_ovr ? 4'd2 : 4'd4;
    has_modrm = 1'b0;
    imm_n     = 4'd0;
    disp_n    = 4'd0;
    if (op_n == 2'd2) begin
      if (op1[7:4] == 4'h8) imm_n = immz;   // Jcc rel16/32
      else                  has_modrm = 1'b1;
    end else begin
      casez (op0)
        8'b00???0??:                 has_modrm = 1'b1;           // ALU r/m forms
        8'b00???100:                 imm_n = 4'd1;               // ALU AL,imm8
        8'b00???101:                 imm_n = immz;               // ALU eAX,immz
        8'h62, 8'h63, 8'hC4, 8'hC5,
        8'b100001??, 8'b10001???,
        8'b110100??, 8'b11011???,
        8'hFE, 8'hFF:                has_modrm = 1'b1;
        8'h69, 8'h81, 8'hC7:         begin has_modrm = 1'b1; imm_n = immz; end
        8'h6B, 8'h80, 8'h82, 8'h83,
        8'hC0, 8'hC1, 8'hC6:         begin has_modrm = 1'b1; imm_n = 4'd1; end
        8'h68, 8'hA9, 8'b10111???,
        8'hE8, 8'hE9:                imm_n = immz;
        8'h6A, 8'b0111????, 8'hA8,
        8'b10110???, 8'hCD, 8'hD4,
        8'hD5, 8'b11100???, 8'hEB:   imm_n = 4'd1;
        8'hC2, 8'hCA:                imm_n = 4'd2;
        8'hC8:                       imm_n = 4'd3;
        8'h9A, 8'hEA:                imm_n = size_ovr ? 4'd4 : 4'd6; // far ptr
        8'b101000??:                 disp_n = addr_ovr ? 4'd2 : 4'd4; // moffs
        8'hF6: begin has_modrm = 1'b1; imm_n = (modrm[5:4] == 2'b00) ? 4'd1 : 4'd0; end
        8'hF7: begin has_modrm = 1'b1; imm_n = (modrm[5:4] == 2'b00) ? immz : 4'd0; end
        default: ;
      endcase
    end
    addr_n = 2'd0;
    if (has_modrm) begin
      addr_n = 2'd1;
      if (addr_ovr) begin
        // 16-bit addressing: no SIB, disp16 for the bare [disp16] form
        if (modrm[7:6] == 2'b00 && modrm[2:0] == 3'd6) disp_n = 4'd2;
        else if (modrm[7:6] == 2'b01)                  disp_n = 4'd1;
        else if (modrm[7:6] == 2'b10)                  disp_n = 4'd2;
      end else begin
        if (modrm[7:6] != 2'b11 && modrm[2:0] == 3'd4) begin
          addr_n = 2'd2;
          if (modrm[7:6] == 2'b00 && sib[2:0] == 3'd5) disp_n = 4'd4;
        end
        if (modrm[7:6] == 2'b00 && modrm[2:0] == 3'd5) disp_n = 4'd4;
        else if (modrm[7:6] == 2'b01)                  disp_n = 4'd1;
        else if (modrm[7:6] == 2'b10)                  disp_n = 4'd4;
      end
    end
    len    = 5'(pfx_n) + 5'(op_n) + 5'(addr_n) + 5'(disp_n) + 5'(imm_n);
    start  = 4'(pfx_n) + 4'(op_n) + 4'(addr_n);
    dni_n  = disp_n + imm_n;
    dni_sh = f_instruction >> {start, 3'b000};
    dni    = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < dni_n) dni[8*k +: 8] = dni_sh[8*k +: 8];
    end
  end

  assign f_bytes_read = CNTW'(len);
  assign f_ready = (f_bytes_read <= f_valid_bytes) && (count_q != CW'(OUT_DEPTH)) &&
                   (state_q == RUN) && !flush && reset;
  assign fire = f_valid && f_ready;
  assign pop  = s0_valid && s0_ready;

  always_comb begin
    rec_d              = '0;
    rec_d.prefix       = {(pfx_n == 2'd3) ? b2 : 8'h00, (pfx_n >= 2'd2) ? b1 : 8'h00,
                          (pfx_n >= 2'd1) ? b0 : 8'h00};
    rec_d.prefix_n     = pfx_n;
    rec_d.opcode       = {(op_n == 2'd2) ? op1 : 8'h00, op0};
    rec_d.opcode_n     = op_n;
    rec_d.addressing   = {(addr_n == 2'd2) ? sib : 8'h00, (addr_n != 2'd0) ? modrm : 8'h00};
    rec_d.addressing_n = addr_n;
    rec_d.disp_n       = disp_n;
    rec_d.imm_n        = imm_n;
    rec_d.dni          = dni;
    rec_d.length       = len;
    rec_d.pc           = f_pc;
    rec_d.branch_taken = f_branch_taken;
    rec_d.size_ovr     = size_ovr;
  end

  // Queue pointer / occupancy and HLT state next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = RUN;
    end else begin
      if (fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (fire && !pop)      count_d = count_q + CW'(1);
      else if (!fire && pop) count_d = count_q - CW'(1);
      if (state_q == RUN && fire && op0 == 8'hF4) state_d = HALTED;
      else if (state_q == HALTED && handle_int)   state_d = RUN;
    end
  end

  // Register stage: queue storage, pointers and state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
      halt_q   <= 1'b0;
    end else begin
      if (fire) mem_q[wr_ptr_q] <= rec_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      halt_q   <= (state_d == HALTED);
    end
  end

  assign rec_q                 = mem_q[rd_ptr_q];
  assign halt                  = halt_q;
  assign s0_valid              = (count_q != '0);
  assign s0_prefix             = rec_q.prefix;
  assign s0_prefix_bytes       = rec_q.prefix_n;
  assign s0_opcode             = rec_q.opcode;
  assign s0_opcode_bytes       = rec_q.opcode_n;
  assign s0_addressing         = rec_q.addressing;
  assign s0_addressing_bytes   = rec_q.addressing_n;
  assign s0_displacement_bytes = rec_q.disp_n;
  assign s0_immediete_bytes    = rec_q.imm_n;
  assign s0_displace_n_imm     = rec_q.dni;
  assign s0_length             = rec_q.length;
  assign s0_pc                 = rec_q.pc;
  assign s0_branch_taken       = rec_q.branch_taken;
  assign s0_size_override      = rec_q.size_ovr;

endmodule

// File: tb/tb_decode_stage_0_q.sv
// Testbench for decode_stage_0_q: directed instruction windows, expected
// records queued at issue time and compared by an independent monitor.
module tb_decode_stage_0_q;
  logic         clk = 1'b0;
  logic         reset, flush, handle_int, halt;
  logic         f_valid, f_ready, f_branch_taken;
  logic [5:0]   f_bytes_read, f_valid_bytes;
  logic [127:0] f_instruction;
  logic [31:0]  f_pc;
  logic         s0_valid, s0_ready;
  logic [23:0]  s0_prefix;
  logic [1:0]   s0_prefix_bytes, s0_opcode_bytes, s0_addressing_bytes;
  logic [15:0]  s0_opcode, s0_addressing;
  logic [3:0]   s0_displacement_bytes, s0_immediete_bytes;
  logic [63:0]  s0_displace_n_imm;
  logic [4:0]   s0_length;
  logic [31:0]  s0_pc;
  logic         s0_branch_taken, s0_size_override;

  decode_stage_0_q dut (
    .clk(clk), .reset(reset), .flush(flush), .handle_int(handle_int), .halt(halt),
    .f_valid(f_valid), .f_ready(f_ready), .f_bytes_read(f_bytes_read),
    .f_valid_bytes(f_valid_bytes), .f_instruction(f_instruction), .f_pc(f_pc),
    .f_branch_taken(f_branch_taken), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_prefix(s0_prefix), .s0_prefix_bytes(s0_prefix_bytes), .s0_opcode(s0_opcode),
    .s0_opcode_bytes(s0_opcode_bytes), .s0_addressing(s0_addressing),
    .s0_addressing_bytes(s0_addressing_bytes), .s0_displacement_bytes(s0_displacement_bytes),
    .s0_immediete_bytes(s0_immediete_bytes), .s0_displace_n_imm(s0_displace_n_imm),
    .s0_length(s0_length), .s0_pc(s0_pc), .s0_branch_taken(s0_branch_taken),
    .s0_size_override(s0_size_override)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pfx;  logic [1:0] pfx_n;
    logic [15:0] op;   logic [1:0] op_n;
    logic [15:0] addr; logic [1:0] addr_n;
    logic [3:0]  dn;   logic [3:0] in;
    logic [63:0] dni;  logic [4:0] len;
    logic [31:0] pc;   logic bt; logic so;
  } rec_t;

  rec_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mkwin(input logic [63:0] seq, input int n);
    logic [127:0] w;
    w = {16{8'hCC}};
    for (int i = 0; i < n; i++) w[8*i +: 8] = seq[8*(n-1-i) +: 8];
    return w;
  endfunction

  function automatic rec_t mkrec(input logic [23:0] pfx, input logic [1:0] pfx_n,
                                 input logic [15:0] op, input logic [1:0] op_n,
                                 input logic [15:0] addr, input logic [1:0] addr_n,
                                 input logic [3:0] dn, input logic [3:0] in,
                                 input logic [63:0] dni, input logic [4:0] len,
                                 input logic [31:0] pc, input logic bt, input logic so);
    rec_t r;
    r.pfx = pfx; r.pfx_n = pfx_n; r.op = op; r.op_n = op_n; r.addr = addr;
    r.addr_n = addr_n; r.dn = dn; r.in = in; r.dni = dni; r.len = len;
    r.pc = pc; r.bt = bt; r.so = so;
    return r;
  endfunction

  function automatic rec_t nop_rec(input logic [31:0] pc);
    return mkrec(24'h0, 2'd0, 16'h0090, 2'd1, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0, 5'd1, pc, 1'b0, 1'b0);
  endfunction

  // Present a window and hold it until accepted; the expected record is
  // queued at the accepting edge. Called between posedge and negedge.
  task automatic offer(input logic [63:0] seq, input int n, input logic [5:0] vb,
                       input logic [31:0] pc, input logic bt, input rec_t exp);
    bit done = 1'b0;
    f_instruction = mkwin(seq, n);
    f_valid_bytes = vb;
    f_pc = pc;
    f_branch_taken = bt;
    f_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (f_ready) begin
        expq.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("offer_fire", 64'(f_ready), 64'd1);
    f_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && expq.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each popped record against the scoreboard head
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset && s0_valid && s0_ready) begin
        chk("sb_has_entry", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("prefix", 64'(s0_prefix), 64'(e.pfx));
          chk("prefix_bytes", 64'(s0_prefix_bytes), 64'(e.pfx_n));
          chk("opcode", 64'(s0_opcode), 64'(e.op));
          chk("opcode_bytes", 64'(s0_opcode_bytes), 64'(e.op_n));
          chk("addressing", 64'(s0_addressing), 64'(e.addr));
          chk("addressing_bytes", 64'(s0_addressing_bytes), 64'(e.addr_n));
          chk("disp_bytes", 64'(s0_displacement_bytes), 64'(e.dn));
          chk("imm_bytes", 64'(s0_immediete_bytes), 64'(e.in));
          chk("displace_n_imm", s0_displace_n_imm, e.dni);
          chk("length", 64'(s0_length), 64'(e.len));
          chk("pc", 64'(s0_pc), 64'(e.pc));
          chk("branch_taken", 64'(s0_branch_taken), 64'(e.bt));
          chk("size_override", 64'(s0_size_override), 64'(e.so));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset = 1'b0; flush = 1'b0; handle_int = 1'b0; f_valid = 1'b0;
    f_valid_bytes = 6'd16; f_instruction = mkwin(64'h90, 1); f_pc = '0;
    f_branch_taken = 1'b0; s0_ready = 1'b0;
    #2;
    chk("rst_s0_valid", 64'(s0_valid), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_f_ready", 64'(f_ready), 64'd0);
    chk("rst_length", 64'(s0_length), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single NOP
    s0_ready = 1'b1;
    f_instruction = mkwin(64'h90, 1); f_valid_bytes = 6'd16; #1;
    chk("nop_bytes_read", 64'(f_bytes_read), 64'd1);
    offer(64'h90, 1, 6'd16, 32'h1000, 1'b0, nop_rec(32'h1000));
    chk("nop_latency_valid", 64'(s0_valid), 64'd1);
    chk("nop_latency_len", 64'(s0_length), 64'd1);

    // Prefixes, displacement, immediates
    offer(64'h66053412, 4, 6'd16, 32'h1001, 1'b1,
          mkrec(24'h000066, 2'd1, 16'h0005, 2'd1, 16'h0, 2'd0, 4'd0, 4'd2, 64'h1234, 5'd4, 32'h1001, 1'b1, 1'b1));
    offer(64'h8B8378563412, 6, 6'd16, 32'h2000, 1'b0,
          mkrec(24'h0, 2'd0, 16'h008B, 2'd1, 16'h0083, 2'd1, 4'd4, 4'd0, 64'h12345678, 5'd6, 32'h2000, 1'b0, 1'b0));
    offer(64'hC744240878563412, 8, 6'd16, 32'h2010, 1'b0,
          mkrec(24'h0, 2'd0, 16'h00C7, 2'd1, 16'h2444, 2'd2, 4'd1, 4'd4, 64'h1234567808, 5'd8, 32'h2010, 1'b0, 1'b0));
    offer(64'h0F8410000000, 6, 6'd16, 32'h2020, 1'b1,
          mkrec(24'h0, 2'd0, 16'h840F, 2'd2, 16'h0, 2'd0, 4'd0, 4'd4, 64'h10, 5'd6, 32'h2020, 1'b1, 1'b0));
    offer(64'hF366A5, 3, 6'd16, 32'h2030, 1'b0,
          mkrec(24'h0066F3, 2'd2, 16'h00A5, 2'd1, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0, 5'd3, 32'h2030, 1'b0, 1'b1));
    drain();

    // Short window
    f_instruction = mkwin(64'h8B8378563412, 6); f_valid_bytes = 6'd3; f_valid = 1'b1;
    @(negedge clk);
    chk("short_bytes_read", 64'(f_bytes_read), 64'd6);
    chk("short_f_ready", 64'(f_ready), 64'd0);
    @(negedge clk);
    chk("short_no_enqueue", 64'(s0_valid), 64'd0);
    @(posedge clk); #1;
    offer(64'h8B8378563412, 6, 6'd6, 32'h2100, 1'b0,
          mkrec(24'h0, 2'd0, 16'h008B, 2'd1, 16'h0083, 2'd1, 4'd4, 4'd0, 64'h12345678, 5'd6, 32'h2100, 1'b0, 1'b0));
    drain();

    // Backpressure: two accepted, third blocked until a pop frees space
    s0_ready = 1'b0;
    offer(64'h90, 1, 6'd16, 32'h3000, 1'b0, nop_rec(32'h3000));
    offer(64'h90, 1, 6'd16, 32'h3001, 1'b0, nop_rec(32'h3001));
    f_instruction = mkwin(64'h90, 1); f_pc = 32'h3002; f_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("full_f_ready", 64'(f_ready), 64'd0);
      chk("full_head_pc", 64'(s0_pc), 64'h3000);
    end
    @(posedge clk); #1;
    s0_ready = 1'b1;
    #1;
    chk("full_blocks_with_pop", 64'(f_ready), 64'd0);
    offer(64'h90, 1, 6'd16, 32'h3002, 1'b0, nop_rec(32'h3002));
    drain();

    // Sustained stream across pointer wrap, one per cycle
    c0 = cyc;
    for (int i = 0; i < 10; i++)
      offer(64'h90, 1, 6'd16, 32'h3100 + 32'(i), 1'b0, nop_rec(32'h3100 + 32'(i)));
    chk("throughput_cycles", 64'(cyc - c0), 64'd10);
    drain();

    // HLT then interrupt
    offer(64'hF4, 1, 6'd16, 32'h4000, 1'b0,
          mkrec(24'h0, 2'd0, 16'h00F4, 2'd1, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0, 5'd1, 32'h4000, 1'b0, 1'b0));
    chk("hlt_halt", 64'(halt), 64'd1);
    f_instruction = mkwin(64'h90, 1); f_pc = 32'h4001; f_valid = 1'b1; #1;
    chk("hlt_f_ready", 64'(f_ready), 64'd0);
    @(posedge clk); #1;
    handle_int = 1'b1; #1;
    chk("hlt_hold_halt", 64'(halt), 64'd1);
    chk("hlt_hold_f_ready", 64'(f_ready), 64'd0);
    @(posedge clk); #1;
    handle_int = 1'b0; #1;
    chk("int_halt_low", 64'(halt), 64'd0);
    chk("int_f_ready", 64'(f_ready), 64'd1);
    offer(64'h90, 1, 6'd16, 32'h4001, 1'b0, nop_rec(32'h4001));
    drain();

    // HLT then flush
    offer(64'hF4, 1, 6'd16, 32'h4100, 1'b0,
          mkrec(24'h0, 2'd0, 16'h00F4, 2'd1, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0, 5'd1, 32'h4100, 1'b0, 1'b0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    chk("flush_exits_halt", 64'(halt), 64'd0);
    drain();

    // Flush with two queued entries
    s0_ready = 1'b0;
    offer(64'h90, 1, 6'd16, 32'h5000, 1'b0, nop_rec(32'h5000));
    offer(64'h90, 1, 6'd16, 32'h5001, 1'b0, nop_rec(32'h5001));
    f_instruction = mkwin(64'h90, 1); f_pc = 32'h5002; f_valid = 1'b1; flush = 1'b1; #1;
    chk("flush_f_ready", 64'(f_ready), 64'd0);
    @(posedge clk); #1;
    expq.delete();
    chk("flush_s0_valid", 64'(s0_valid), 64'd0);
    // Flush with an empty queue must still suppress the fire
    #1;
    chk("flush_empty_f_ready", 64'(f_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; f_valid = 1'b0;
    chk("flush_empty_no_enqueue", 64'(s0_valid), 64'd0);

    // Asynchronous reset mid-stream
    offer(64'h90, 1, 6'd16, 32'h6000, 1'b0, nop_rec(32'h6000));
    chk("pre_reset_valid", 64'(s0_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_s0_valid", 64'(s0_valid), 64'd0);
    chk("areset_length", 64'(s0_length), 64'd0);
    chk("areset_pc", 64'(s0_pc), 64'd0);
    chk("areset_opcode", 64'(s0_opcode), 64'd0);
    chk("areset_halt", 64'(halt), 64'd0);
    expq.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    s0_ready = 1'b1;
    @(posedge clk); #1;
    offer(64'h90, 1, 6'd16, 32'h7000, 1'b0, nop_rec(32'h7000));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
